// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the IO-controller / memory-controller command interface.
//   DATA_W_DEF / ADDR_W_DEF / MEM_DEPTH_DEF : default widths and depth
//   mem_cmd_t   : command encoding carried on memCmd
//   mem_state_t : memory controller FSM states
package mem_ctrl_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned ADDR_W_DEF    = 64;
    localparam int unsigned MEM_DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_RESET = 2'b11
    } mem_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        READ_WAIT,
        CLEAR,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with one-cycle read latency. Contents are not reset.
//   clk   : clock
//   we    : write enable, writes wdata to mem[addr]
//   addr  : word address
//   wdata : write data
//   rdata : registered read data of mem[addr] from the previous cycle
module mem_array #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_control.sv
// Memory-side responder: executes CLEAR/WRITE/READ/RESET commands from the IO controller
// against the on-chip word memory.
//   clk, rst      : clock, synchronous active-high reset
//   memCmd        : command (see mem_cmd_t)
//   ioDataIn      : write data (WRITE only)
//   memAddrIn     : word address (WRITE/READ only)
//   ioCmdDoneIn   : command valid, a rising edge issues one command
//   memCmdDoneOut : 1 = idle/complete, 0 = busy
//   memDataOut    : read result, held until an accepted command changes it
//   memErrOut     : 1 = last command used an out-of-range address
module mem_control
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        memCmd,
    input  logic [DATA_W-1:0] ioDataIn,
    input  logic [ADDR_W-1:0] memAddrIn,
    input  logic              ioCmdDoneIn,
    output logic              memCmdDoneOut,
    output logic [DATA_W-1:0] memDataOut,
    output logic              memErrOut
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    mem_state_t        state;
    mem_cmd_t          cmdIn;
    logic              ioCmdDonePrev;
    logic              cmdEdge;
    logic              addrOk;
    logic [AW-1:0]     addrQ;
    logic [DATA_W-1:0] dataQ;
    logic [AW-1:0]     sweepCnt;
    logic              ramWe;
    logic [AW-1:0]     ramAddr;
    logic [DATA_W-1:0] ramWdata;
    logic [DATA_W-1:0] ramRdata;

    assign cmdEdge = ioCmdDoneIn & ~ioCmdDonePrev;
    assign cmdIn   = mem_cmd_t'(memCmd);
    // In range iff every bit above the implemented index is zero.
    assign addrOk  = (memAddrIn[ADDR_W-1:AW] == '0);

    // RAM port steering; a write in the reset cycle is suppressed so an aborted sweep stops cleanly.
    always_comb begin
        ramWe    = 1'b0;
        ramAddr  = addrQ;
        ramWdata = dataQ;
        if (state == CLEAR) begin
            ramWe    = ~rst;
            ramAddr  = sweepCnt;
            ramWdata = '0;
        end else if (state == WRITE) begin
            ramWe    = ~rst;
        end
    end

    mem_array #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (ramWe),
        .addr  (ramAddr),
        .wdata (ramWdata),
        .rdata (ramRdata)
    );

    // Command FSM with edge detect, command latches, sweep counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ioCmdDonePrev <= 1'b0;
            sweepCnt      <= '0;
            memCmdDoneOut <= 1'b1;
            memDataOut    <= '0;
            memErrOut     <= 1'b0;
        end else begin
            ioCmdDonePrev <= ioCmdDoneIn;
            case (state)
                IDLE: begin
                    if (cmdEdge) begin
                        addrQ         <= memAddrIn[AW-1:0];
                        dataQ         <= ioDataIn;
                        memErrOut     <= 1'b0;
                        memCmdDoneOut <= 1'b0;
                        case (cmdIn)
                            CMD_CLEAR: begin
                                memDataOut <= '0;
                                sweepCnt   <= '0;
                                state      <= CLEAR;
                            end
                            CMD_WRITE: begin
                                if (addrOk) begin
                                    state <= WRITE;
                                end else begin
                                    memErrOut <= 1'b1;
                                    state     <= DONE;
                                end
                            end
                            CMD_READ: begin
                                if (addrOk) begin
                                    state <= READ;
                                end else begin
                                    memErrOut <= 1'b1;
                                    state     <= DONE;
                                end
                            end
                            default: begin
                                memDataOut <= '0;
                                state      <= DONE;
                            end
                        endcase
                    end
                end
                WRITE:     state <= DONE;
                READ:      state <= READ_WAIT;
                READ_WAIT: begin
                    memDataOut <= ramRdata;
                    state      <= DONE;
                end
                CLEAR: begin
                    if (sweepCnt == AW'(MEM_DEPTH - 1)) begin
                        sweepCnt <= '0;
                        state    <= DONE;
                    end else begin
                        sweepCnt <= sweepCnt + 1'b1;
                    end
                end
                DONE: begin
                    memCmdDoneOut <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_control.sv
// Randomized bench for mem_control against a word-array reference model.
module tb_mem_control;
    import mem_ctrl_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AWID  = 64;
    localparam int unsigned DEPTH = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      memCmd;
    logic [DW-1:0]   ioDataIn;
    logic [AWID-1:0] memAddrIn;
    logic            ioCmdDoneIn;
    logic            memCmdDoneOut;
    logic [DW-1:0]   memDataOut;
    logic            memErrOut;

    mem_control dut (
        .clk           (clk),
        .rst           (rst),
        .memCmd        (memCmd),
        .ioDataIn      (ioDataIn),
        .memAddrIn     (memAddrIn),
        .ioCmdDoneIn   (ioCmdDoneIn),
        .memCmdDoneOut (memCmdDoneOut),
        .memDataOut    (memDataOut),
        .memErrOut     (memErrOut)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] expData;
    logic        expErr;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Edges from raising ioCmdDoneIn until done is seen high again.
    function automatic int expLatency(input mem_cmd_t cmd, input logic [63:0] addr);
        bit ok = (addr < 64'(DEPTH));
        case (cmd)
            CMD_CLEAR: return DEPTH + 2;
            CMD_WRITE: return ok ? 3 : 2;
            CMD_READ:  return ok ? 4 : 2;
            default:   return 2;
        endcase
    endfunction

    task automatic modelCmd(input mem_cmd_t cmd, input logic [63:0] addr, input logic [31:0] data);
        bit ok = (addr < 64'(DEPTH));
        case (cmd)
            CMD_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
                expData = '0;
                expErr  = 1'b0;
            end
            CMD_WRITE: begin
                expErr = !ok;
                if (ok) mdl[addr[7:0]] = data;
            end
            CMD_READ: begin
                expErr = !ok;
                if (ok) expData = mdl[addr[7:0]];
            end
            default: begin
                expData = '0;
                expErr  = 1'b0;
            end
        endcase
    endtask

    // Issue one command; hold the valid level for 'hold' edges, optionally pulse a stray
    // WRITE at edge 'pulseAt'. Checks latency, single completion, data and error flag.
    task automatic runCmd(input mem_cmd_t cmd, input logic [63:0] addr, input logic [31:0] data,
                          input int hold, input int pulseAt);
        int   n = 0;
        int   lat = 0;
        int   completions = 0;
        logic prevDone = 1'b1;
        memCmd      = cmd;
        memAddrIn   = addr;
        ioDataIn    = data;
        ioCmdDoneIn = 1'b1;
        while ((lat == 0 || n < hold) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (memCmdDoneOut && !prevDone) begin
                completions++;
                if (lat == 0) lat = n;
            end
            prevDone = memCmdDoneOut;
            if (n == 5 && n < hold) ioDataIn = ~data;
            if (n == hold) ioCmdDoneIn = 1'b0;
            if (pulseAt != 0 && n == pulseAt) begin
                memCmd      = CMD_WRITE;
                memAddrIn   = 64'd3;
                ioDataIn    = 32'h5A5A_5A5A;
                ioCmdDoneIn = 1'b1;
            end
            if (pulseAt != 0 && n == pulseAt + 1) ioCmdDoneIn = 1'b0;
        end
        modelCmd(cmd, addr, data);
        checkVal($sformatf("latency %s a=%0h", cmd.name(), addr), 64'(lat), 64'(expLatency(cmd, addr)));
        checkVal($sformatf("completions %s", cmd.name()), 64'(completions), 64'd1);
        checkVal($sformatf("data %s a=%0h", cmd.name(), addr), 64'(memDataOut), 64'(expData));
        checkVal($sformatf("err %s a=%0h", cmd.name(), addr), 64'(memErrOut), 64'(expErr));
        ioCmdDoneIn = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        memCmd      = '0;
        ioDataIn    = '0;
        memAddrIn   = '0;
        ioCmdDoneIn = 1'b0;
        expData     = '0;
        expErr      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("reset done", 64'(memCmdDoneOut), 64'd1);
        checkVal("reset data", 64'(memDataOut), 64'd0);
        checkVal("reset err", 64'(memErrOut), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Memory powers up undefined, so start from a known cleared state.
        runCmd(CMD_CLEAR, 64'd0, 32'd0, 1, 0);

        // Write then read back.
        runCmd(CMD_WRITE, 64'h05, 32'hDEAD_BEEF, 1, 0);
        runCmd(CMD_READ,  64'h05, 32'd0, 1, 0);

        // Out-of-range read, then a valid read clears the error.
        runCmd(CMD_READ, 64'h1_0000_0000, 32'd0, 1, 0);
        runCmd(CMD_READ, 64'h05, 32'd0, 1, 0);
        runCmd(CMD_WRITE, 64'd256, 32'h1111_2222, 1, 0);

        // Fill boundary addresses, clear, read back zeros.
        runCmd(CMD_WRITE, 64'd0,   32'hA0A0_0001, 1, 0);
        runCmd(CMD_WRITE, 64'd7,   32'hA0A0_0007, 1, 0);
        runCmd(CMD_WRITE, 64'd255, 32'hA0A0_00FF, 1, 0);
        runCmd(CMD_READ,  64'd255, 32'd0, 1, 0);
        runCmd(CMD_CLEAR, 64'd0, 32'd0, 1, 0);
        runCmd(CMD_READ,  64'd0,   32'd0, 1, 0);
        runCmd(CMD_READ,  64'd7,   32'd0, 1, 0);
        runCmd(CMD_READ,  64'd255, 32'd0, 1, 0);

        // Held level issues one write; a pulse during CLEAR is dropped.
        runCmd(CMD_WRITE, 64'd9, 32'hCAFE_0009, 20, 0);
        runCmd(CMD_READ,  64'd9, 32'd0, 1, 0);
        runCmd(CMD_CLEAR, 64'd0, 32'd0, 1, 50);
        runCmd(CMD_READ,  64'd3, 32'd0, 1, 0);

        // Reset in the middle of a CLEAR sweep.
        runCmd(CMD_WRITE, 64'd5,  32'h0000_0555, 1, 0);
        runCmd(CMD_WRITE, 64'd20, 32'h0000_2020, 1, 0);
        runCmd(CMD_READ,  64'd20, 32'd0, 1, 0);
        memCmd      = CMD_CLEAR;
        ioCmdDoneIn = 1'b1;
        @(posedge clk);
        #1;
        ioCmdDoneIn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkVal("busy mid clear", 64'(memCmdDoneOut), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) mdl[i] = '0;
        expData = '0;
        expErr  = 1'b0;
        checkVal("abort done", 64'(memCmdDoneOut), 64'd1);
        checkVal("abort data", 64'(memDataOut), 64'd0);
        checkVal("abort err", 64'(memErrOut), 64'd0);
        runCmd(CMD_WRITE, 64'd10, 32'h0000_1010, 1, 0);
        runCmd(CMD_READ,  64'd5,  32'd0, 1, 0);
        runCmd(CMD_READ,  64'd20, 32'd0, 1, 0);

        // RESET command clears output but not memory.
        runCmd(CMD_WRITE, 64'd40, 32'h0000_1234, 1, 0);
        runCmd(CMD_READ,  64'd40, 32'd0, 1, 0);
        runCmd(CMD_RESET, 64'd0,  32'd0, 1, 0);
        runCmd(CMD_READ,  64'd40, 32'd0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            int          r    = int'($urandom % 16);
            int          sel  = int'($urandom % 8);
            int          hold = ($urandom % 4 == 0) ? int'(1 + $urandom % 6) : 1;
            mem_cmd_t    cmd;
            logic [63:0] a;
            logic [31:0] d    = $urandom;
            if (r == 0)      cmd = CMD_CLEAR;
            else if (r < 7)  cmd = CMD_WRITE;
            else if (r < 13) cmd = CMD_READ;
            else             cmd = CMD_RESET;
            case (sel)
                0:       a = {32'($urandom) | 32'h1, 32'($urandom)};
                1:       a = 64'd256;
                2:       a = 64'd255;
                default: a = 64'($urandom % DEPTH);
            endcase
            runCmd(cmd, a, d, hold, 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
